// File: rtl/mux32_scan_ctrl.sv
// Serializer front-end for a 32x1 mux: holds an accepted word on the mux data inputs,
// walks the select across NBITS positions and streams each mux output bit out on valid/ready/last.
module mux32_scan_ctrl #(
    parameter int unsigned NBITS     = 32,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] hold_data,
    output logic [4:0]  sel,
    input  logic        mux_out,
    output logic        ser_bit,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_last,
    output logic        busy
);

    localparam int unsigned IDX_W     = 5;
    localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(NBITS - 1) : IDX_W'(0);
    localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(NBITS - 1);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             capture;
    logic             is_last;
    logic [IDX_W-1:0] sel_next;

    // Capture whenever scanning and the output register is empty or draining this cycle.
    assign capture  = (state == SCAN) && (!ser_valid || ser_ready);
    assign is_last  = (cnt == LAST_CNT);
    assign sel_next = MSB_FIRST ? (sel - IDX_W'(1)) : (sel + IDX_W'(1));

    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state == SCAN) || ser_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            sel       <= '0;
            hold_data <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else if (flush) begin
            // Abort: drop any pending bit, keep the held word for visibility.
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            case (state)
                INIT: state <= IDLE;
                IDLE: begin
                    if (in_valid) begin
                        hold_data <= in_data;
                        cnt       <= '0;
                        sel       <= FIRST_IDX;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (capture) begin
                        if (is_last) begin
                            state <= IDLE;
                            sel   <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                            sel <= sel_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register: a capture refills it, otherwise a handshake empties it.
            if (capture) begin
                ser_bit   <= mux_out;
                ser_valid <= 1'b1;
                ser_last  <= is_last;
            end else if (ser_valid && ser_ready) begin
                ser_valid <= 1'b0;
                ser_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux32_scan_ctrl.sv
// Directed bench: three instances (LSB-first, MSB-first, single-bit) share stimulus,
// each paired with a behavioural 32x1 mux.
module tb_mux32_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        ser_ready;

    logic        a_in_ready, b_in_ready, c_in_ready;
    logic [31:0] a_hold, b_hold, c_hold;
    logic [4:0]  a_sel, b_sel, c_sel;
    logic        a_mux, b_mux, c_mux;
    logic        a_bit, b_bit, c_bit;
    logic        a_valid, b_valid, c_valid;
    logic        a_last, b_last, c_last;
    logic        a_busy, b_busy, c_busy;

    int n_tests = 0;
    int n_fail  = 0;

    assign a_mux = a_hold[a_sel];
    assign b_mux = b_hold[b_sel];
    assign c_mux = c_hold[c_sel];

    mux32_scan_ctrl #(.NBITS(32), .MSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .hold_data(a_hold), .sel(a_sel), .mux_out(a_mux),
        .ser_bit(a_bit), .ser_valid(a_valid), .ser_ready(ser_ready), .ser_last(a_last),
        .busy(a_busy)
    );

    mux32_scan_ctrl #(.NBITS(32), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .hold_data(b_hold), .sel(b_sel), .mux_out(b_mux),
        .ser_bit(b_bit), .ser_valid(b_valid), .ser_ready(ser_ready), .ser_last(b_last),
        .busy(b_busy)
    );

    mux32_scan_ctrl #(.NBITS(1), .MSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(c_in_ready), .hold_data(c_hold), .sel(c_sel), .mux_out(c_mux),
        .ser_bit(c_bit), .ser_valid(c_valid), .ser_ready(ser_ready), .ser_last(c_last),
        .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] w2;
        int          k;
        int          cyc;

        rst_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; ser_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 0);
        chk("rst_hold",     a_hold, 0);
        chk("rst_sel",      32'(a_sel), 0);
        chk("rst_valid",    32'(a_valid), 0);
        chk("rst_bit",      32'(a_bit), 0);
        chk("rst_last",     32'(a_last), 0);
        chk("rst_busy",     32'(a_busy), 0);
        rst_n = 1'b1;
        #1;
        chk("init_in_ready", 32'(a_in_ready), 0);
        step();
        chk("idle_in_ready", 32'(a_in_ready), 1);

        // LSB-first and MSB-first scan of the same word
        w = 32'hA5A5_0F0F;
        in_data = w; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("acc_hold",     a_hold, w);
        chk("acc_sel_a",    32'(a_sel), 0);
        chk("acc_sel_b",    32'(b_sel), 31);
        chk("acc_valid",    32'(a_valid), 0);
        chk("acc_busy",     32'(a_busy), 1);
        chk("acc_in_ready", 32'(a_in_ready), 0);
        for (int i = 0; i < 32; i++) begin
            chk("t1_sel_a", 32'(a_sel), 32'(i));
            chk("t2_sel_b", 32'(b_sel), 32'(31 - i));
            step();
            chk("t1_valid", 32'(a_valid), 1);
            chk("t1_bit",   32'(a_bit), 32'(w[i]));
            chk("t1_last",  32'(a_last), 32'(i == 31));
            chk("t2_bit",   32'(b_bit), 32'(w[31 - i]));
            chk("t2_last",  32'(b_last), 32'(i == 31));
        end
        step();
        chk("t1_drain_valid", 32'(a_valid), 0);
        chk("t1_drain_busy",  32'(a_busy), 0);
        chk("t1_drain_sel",   32'(a_sel), 0);

        // Backpressure: ready pattern 1,0,0,1
        w = 32'h3C96_E1D2;
        in_data = w; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < 32 && cyc < 300) begin
            ser_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (a_valid) begin
                chk("t3_bit",  32'(a_bit), 32'(w[k]));
                chk("t3_last", 32'(a_last), 32'(k == 31));
                chk("t3_sel",  32'(a_sel), (k < 31) ? 32'(k + 1) : 32'd0);
                if (ser_ready) k++;
            end
            step();
            cyc++;
        end
        chk("t3_handshakes", 32'(k), 32);
        ser_ready = 1'b1;
        step();
        chk("t3_idle_valid", 32'(a_valid), 0);

        // Back-to-back words with in_valid held
        w  = 32'h1234_5678;
        w2 = 32'hCAFE_F00D;
        in_data = w; in_valid = 1'b1;
        step();
        in_data = w2;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("t4_w1_bit",  32'(a_bit), 32'(w[i]));
            chk("t4_w1_last", 32'(a_last), 32'(i == 31));
        end
        chk("t4_ready_at_last", 32'(a_in_ready), 1);
        step();
        chk("t4_gap_valid", 32'(a_valid), 0);
        chk("t4_w2_hold",   a_hold, w2);
        chk("t4_w2_ready",  32'(a_in_ready), 0);
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("t4_w2_valid", 32'(a_valid), 1);
            chk("t4_w2_bit",   32'(a_bit), 32'(w2[i]));
            chk("t4_w2_last",  32'(a_last), 32'(i == 31));
        end
        step();

        // Flush mid-word with a word presented in the flush cycle
        w  = 32'h0F0F_5AA5;
        w2 = 32'h8000_0001;
        in_data = w; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_pre_bit", 32'(a_bit), 32'(w[i]));
        end
        flush = 1'b1; in_data = w2; in_valid = 1'b1;
        #1;
        chk("t5_flush_in_ready", 32'(a_in_ready), 0);
        step();
        chk("t5_flush_valid", 32'(a_valid), 0);
        chk("t5_flush_last",  32'(a_last), 0);
        chk("t5_flush_sel",   32'(a_sel), 0);
        chk("t5_flush_hold",  a_hold, w);
        chk("t5_flush_busy",  32'(a_busy), 0);
        flush = 1'b0;
        step();
        in_valid = 1'b0;
        chk("t5_new_hold", a_hold, w2);
        for (int i = 0; i < 32; i++) begin
            step();
            chk("t5_new_bit",  32'(a_bit), 32'(w2[i]));
            chk("t5_new_last", 32'(a_last), 32'(i == 31));
        end

        // Single-bit words
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        chk("t6_c_ready", 32'(c_in_ready), 1);
        in_data = 32'h0000_0001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t6_c_valid1", 32'(c_valid), 1);
        chk("t6_c_bit1",   32'(c_bit), 1);
        chk("t6_c_last1",  32'(c_last), 1);
        in_data = 32'h0000_0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t6_c_gap", 32'(c_valid), 0);
        step();
        chk("t6_c_valid2", 32'(c_valid), 1);
        chk("t6_c_bit2",   32'(c_bit), 0);
        chk("t6_c_last2",  32'(c_last), 1);
        step();
        chk("t6_c_drain", 32'(c_valid), 0);

        // Asynchronous reset in the middle of a scan
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        in_data = 32'hFFFF_FFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("t6_pre_rst_bit", 32'(a_bit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bit",      32'(a_bit), 0);
        chk("t6_rst_valid",    32'(a_valid), 0);
        chk("t6_rst_last",     32'(a_last), 0);
        chk("t6_rst_sel",      32'(a_sel), 0);
        chk("t6_rst_hold",     a_hold, 0);
        chk("t6_rst_in_ready", 32'(a_in_ready), 0);
        chk("t6_rst_busy",     32'(a_busy), 0);
        #10;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux32_scan_ctrl.md
Name: mux32_scan_ctrl

Overview:
Serializer front-end for the 32x1 mux.
- Accepts a 32-bit word on a valid/ready handshake and holds it on the mux data inputs.
- Steps the 5-bit select through NBITS positions and captures each mux output bit into a registered serial stream with valid/ready/last.
- Sits directly upstream of mux32x1 (drives d0..d31 and s0..s4) and consumes its out.

Parameters:
NBITS, 32, bits scanned per word, legal range 1..32; indices 0..NBITS-1 are used.
MSB_FIRST, 0, 0: scan index 0 upward; 1: scan index NBITS-1 downward.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort, highest priority
in_data  input  32  word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word
hold_data  output  32  held word; bit i drives mux d<i>
sel  output  5  mux select; sel[4] drives s0, sel[3] s1, sel[2] s2, sel[1] s3, sel[0] s4 (selected input = d<sel>)
mux_out  input  1  mux32x1 out (combinational from hold_data/sel)
ser_bit  output  1  serial data bit
ser_valid  output  1  ser_bit valid
ser_ready  input  1  downstream accepts ser_bit
ser_last  output  1  marks final bit of word
busy  output  1  state==SCAN or ser_valid

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=INIT, cnt=0, sel=0, hold_data=0, ser_bit=0, ser_valid=0, ser_last=0, in_ready=0, busy=0.
- State machine, transitions evaluated at the clk edge:
  - INIT -> IDLE unconditionally.
  - IDLE -> SCAN on accept.
  - SCAN -> IDLE after capturing bit NBITS-1.
- in_ready = (state==IDLE) && !flush.
- Accept: in_valid && in_ready. On accept:
  - hold_data <= in_data.
  - cnt <= 0.
  - sel <= first index (0, or NBITS-1 if MSB_FIRST).
  - Go to SCAN.
- Capture condition: state==SCAN && (!ser_valid || ser_ready).
- On capture:
  - ser_bit <= mux_out.
  - ser_valid <= 1.
  - ser_last <= (cnt==NBITS-1).
  - If not last: cnt <= cnt+1, and sel moves to the next index (+1, or -1 if MSB_FIRST).
  - If last: state <= IDLE, sel <= 0, cnt <= 0.
- Output consume: ser_valid && ser_ready with no capture in the same cycle -> ser_valid <= 0, ser_last <= 0.
- Stall: while ser_valid && !ser_ready, ser_bit, ser_last, sel and cnt are held stable.
- Latency: accept in cycle N; first capture at the end of N+1; ser_valid=1 from N+2. With ser_ready held 1, one bit per cycle.
- Between words there is one gap cycle with ser_valid=0 (the IDLE accept cycle).
- Last-bit overlap: the block returns to IDLE while the last bit may still sit in the output register. A new word can be accepted then; hold_data may change because the last bit has already been captured.
- flush (synchronous, beats every other event):
  - state <= IDLE, cnt <= 0, sel <= 0, ser_valid <= 0, ser_last <= 0.
  - hold_data unchanged.
  - A word presented in the flush cycle is not accepted.
- NBITS=1: one beat per word, with ser_last=1 on that beat.
- rst_n asserted mid-scan: all registers return to reset values immediately; the partial word is discarded.
- No capture occurs in INIT or IDLE. sel is registered.

Test Plan:
1. Reset, NBITS=32, MSB_FIRST=0, ser_ready=1, send 0xA5A50F0F -> in_ready=1 from 2nd cycle after reset; ser_bit sequence 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1; ser_last only on the 32nd bit; sel goes 0..31.
2. MSB_FIRST=1, send 0xA5A50F0F -> first bits 1,0,1,0,0,1,0,1; sel starts at 31 and descends to 0; ser_last on the bit from sel=0.
3. ser_ready toggled 1,0,0,1 repeatedly -> no bit lost or duplicated; ser_bit and sel stable while stalled; 32 handshakes total.
4. Two words back-to-back with in_valid held -> second accepted in the cycle after the first's last capture; exactly one ser_valid=0 gap; second word bit-exact.
5. flush asserted at bit 10 with in_valid=1 -> ser_valid=0 next cycle; in_ready=0 during the flush cycle; next word serializes from bit 0.
6. NBITS=1, send 0x00000001 then 0x00000000 -> two beats, ser_bit 1 then 0, both with ser_last=1. Also assert rst_n low mid-scan -> all outputs 0 asynchronously.
